// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-to-UART drain block.
// Optional build macro: UART_PARITY_EN selects 8E1 framing instead of 8N1.
package fifo_uart_tx_pkg;

   // Word-level sequencing; the bit-level frame lives in uart_tx_byte.
   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StRdReq,
      StRdWait,
      StLoad,
      StSend,
      StNext,
      StDone
   } drain_state_e;

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      BitIdle,
      BitStart,
      BitData,
      BitParity,
      BitStop
   } bit_state_e;
   localparam int unsigned FRAME_BITS = 11;
`else
   typedef enum logic [2:0] {
      BitIdle,
      BitStart,
      BitData,
      BitStop
   } bit_state_e;
   localparam int unsigned FRAME_BITS = 10;
`endif

   localparam int unsigned DEFAULT_DATA_W = 16;
   localparam logic        UART_IDLE      = 1'b1;

   // Number of bytes carried by one FIFO word.
   function automatic int unsigned bytes_per_word(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_byte.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, optional even
// parity (UART_PARITY_EN), stop bit. tx is registered so the line never glitches.
module uart_tx_byte
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = 4;
   localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(8);

   bit_state_e        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   // Position inside the frame: 0 = start, 1..8 = data, then parity/stop.
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [7:0]        data_q, data_d;
   logic              tx_q, tx_d;
   logic              baud_end;

   assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   // State, counters and the registered serial line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BitIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         tx_q    <= UART_IDLE;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
      end
   end

   // Next state: baud counter restarts at every bit boundary.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;
      if (state_q == BitIdle) begin
         if (start) begin
            state_d = BitStart;
            data_d  = byte_in;
            baud_d  = '0;
            bit_d   = '0;
         end
      end else if (baud_end) begin
         baud_d = '0;
         bit_d  = bit_q + BIT_W'(1);
         unique case (state_q)
            BitStart: state_d = BitData;
            BitData: begin
               if (bit_q == LAST_DATA_BIT) begin
`ifdef UART_PARITY_EN
                  state_d = BitParity;
`else
                  state_d = BitStop;
`endif
               end
            end
`ifdef UART_PARITY_EN
            BitParity: state_d = BitStop;
`endif
            BitStop:  state_d = BitIdle;
            default:  state_d = BitIdle;
         endcase
      end else begin
         baud_d = baud_q + BAUD_W'(1);
      end
   end

   // Line level for the upcoming cycle, derived from the next state.
   always_comb begin
      tx_d = UART_IDLE;
      unique case (state_d)
         BitStart:  tx_d = 1'b0;
         BitData:   tx_d = data_d[bit_d[2:0] - 3'd1];
`ifdef UART_PARITY_EN
         BitParity: tx_d = ^data_d;
`endif
         default:   tx_d = UART_IDLE;
      endcase
   end

   assign tx   = tx_q;
   assign busy = (state_q != BitIdle);
   // Last cycle of the stop bit.
   assign done = baud_end && (bit_q == BIT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the sample FIFO over UART: one rd pulse per word, then the word's
// bytes MSB byte first. Drain starts on a rising edge of send_i and ends when
// the FIFO reports empty. Optional build macro: UART_PARITY_EN (8E1 frames).
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_W       = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send_i,
   input  logic              empty_i,
   input  logic [DATA_W-1:0] dato_i,
   output logic              rd_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_W);
   localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   drain_state_e      state_q, state_d;
   logic              send_q;
   logic              send_edge;
   // Bytes of the current word not yet handed to the byte transmitter.
   logic [DATA_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              rd_q, rd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              byte_start;
   logic [7:0]        byte_in;
   logic              byte_busy;
   logic              byte_done;

   assign send_edge = send_i & ~send_q & ~busy_q;

   // FSM state and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Button history and word shift register; send_q resets high so a held
   // button does not start a drain when reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         send_q <= 1'b1;
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         send_q <= send_i;
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   // Next-state logic; empty_i matters only in StCheck.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (send_edge) state_d = StCheck;
         StCheck:  state_d = empty_i ? StDone : StRdReq;
         StRdReq:  state_d = StRdWait;
         StRdWait: state_d = StLoad;
         StLoad:   state_d = StSend;
         // !byte_busy only guards against a lost done; normally byte_done ends it.
         StSend:   if (byte_done || !byte_busy) state_d = StNext;
         StNext:   state_d = (idx_q != '0) ? StSend : StCheck;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs and byte sequencing; LOAD sends dato_i's top byte directly.
   always_comb begin
      word_d     = word_q;
      idx_d      = idx_q;
      byte_start = 1'b0;
      byte_in    = word_q[DATA_W-1 -: 8];
      rd_d       = (state_d == StRdReq);
      busy_d     = (state_d != StIdle) && (state_d != StDone);
      done_d     = (state_d == StDone);
      unique case (state_q)
         StLoad: begin
            word_d     = dato_i << 8;
            idx_d      = IDX_W'(BYTES_PER_WORD - 1);
            byte_start = 1'b1;
            byte_in    = dato_i[DATA_W-1 -: 8];
         end
         StNext: begin
            if (idx_q != '0) begin
               word_d     = word_q << 8;
               idx_d      = idx_q - IDX_W'(1);
               byte_start = 1'b1;
            end
         end
         default: ;
      endcase
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk    (clk),
      .rst    (rst),
      .start  (byte_start),
      .byte_in(byte_in),
      .tx     (tx_o),
      .busy   (byte_busy),
      .done   (byte_done)
   );

   assign rd_o   = rd_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Reader side of the filtered-sample FIFO. It drains the FIFO into a UART link toward the PC.
- A rising edge on send_i starts a drain.
- For each 16-bit word: one rd_en pulse, then two 8N1 byte frames, MSB byte first.
- The drain ends when the FIFO reports empty.
- Sits between the memoria FIFO outputs (dato_out, empty) and the board TX pin. It replaces control's rd_o path during transmission.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Must be >= 2.
DATA_W, 16, FIFO word width. Must be a multiple of 8.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
send_i  in  1  level from the send pushbutton (already debounced); drain starts on its rising edge
empty_i  in  1  FIFO empty flag
dato_i  in  DATA_W  FIFO read data; valid one cycle after rd_o
rd_o  out  1  FIFO read enable; single-cycle pulse per word
tx_o  out  1  UART serial line; idles high
busy_o  out  1  high from drain start until drain end
done_o  out  1  one-cycle pulse when the drain completes

Behaviour:
- Reset (async, immediate):
  - tx_o=1, rd_o=0, busy_o=0, done_o=0.
  - State=IDLE, all counters 0, send edge register cleared to 1. This prevents a held button from triggering a drain on reset release.
- Edge detect: send_q is send_i registered. An edge is send_i=1 & send_q=0. Edges while busy_o=1 are ignored.
- FSM states: IDLE, CHECK, RD_REQ, RD_WAIT, LOAD, START, DATA, STOP, NEXT, DONE.
- IDLE: on edge go to CHECK and set busy_o=1 in the next cycle.
- CHECK: if empty_i=1 go to DONE; otherwise go to RD_REQ.
- RD_REQ: rd_o=1 for exactly this cycle, then RD_WAIT.
- RD_WAIT: one cycle while the FIFO presents data, then LOAD.
- LOAD: latch dato_i into a shift register; byte index = DATA_W/8-1 (MSB byte first); go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
- STOP: tx_o=1 for CLKS_PER_BIT cycles.
- NEXT:
  - If bytes remain: decrement the byte index, go to START (no idle gap beyond this 1 cycle).
  - Otherwise go to CHECK.
- DONE: done_o=1 for one cycle, busy_o returns to 0, then IDLE.
- Latency: edge at cycle N → CHECK at N+1 → rd_o high at N+2 → LOAD at N+4 → start bit begins at N+5.
- Frame length: 10*CLKS_PER_BIT cycles. Word period: 20*CLKS_PER_BIT + 2 cycles, plus 4 cycles of read overhead.
- empty_i is sampled only in CHECK. A word written during a transmission is sent in the same drain.
- tx_o is registered (glitch-free); rd_o is registered.
- Baud counter resets at every bit boundary and wraps at CLKS_PER_BIT-1.

Optional Feature:
UART_PARITY_EN:
- Defined: a PARITY state follows DATA and sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bits (8E1).
- Undefined: no PARITY state, 8N1 frame, no parity logic synthesized.

Decomposition:
- Package fifo_uart_tx_pkg:
  - state enum.
  - Constants: BYTES_PER_WORD = DATA_W/8, UART_IDLE = 1'b1, FRAME_BITS (10 or 11 depending on UART_PARITY_EN).
- Sub-module uart_tx_byte:
  - Ports: start, byte_in → tx, busy, done.
  - Owns the baud counter, bit counter, START/DATA/PARITY/STOP.
  - The top owns the FIFO handshake, byte sequencing and send edge detection.

Test Plan:
- Reset, then release → tx_o=1, rd_o=0, busy_o=0, done_o=0. Assert rst mid-idle → outputs unchanged.
- CLKS_PER_BIT=4, FIFO {0xA55A}, send_i rises at N:
  - rd_o pulse at N+2.
  - tx_o carries 0xA5 then 0x5A, each as bits 0, LSB-first data, 1.
  - done_o pulses; busy_o=0 afterward.
- FIFO empty, send_i rises → no rd_o, tx_o stays 1, done_o at N+2.
- FIFO {0x0001,0x8000,0xFFFF}, send_i held high 500 cycles → exactly 3 rd_o pulses, 6 bytes (00 01 80 00 FF FF), a single done_o.
- rst asserted during a DATA bit with tx_o=0 → tx_o=1 in the same cycle (async), busy_o=0. After release, with send_i still high → no new drain.
- UART_PARITY_EN defined, byte 0x03 → parity bit 0, byte 0x07 → parity bit 1; frame = 11*CLKS_PER_BIT cycles.
